alu_issue_scheduler: RTL and testbench
======================================

# alu_issue_scheduler

Shares the single two-stage scalar ALU pipeline among NREQ vector-lane requesters. Each cycle it picks at most one pending operation by round-robin, registers it into an issue stage that feeds the ALU's fr_* inputs, and carries a requester tag alongside the op through the ALU's fixed latency. When the result emerges it is routed back to the originating lane. Sits between the lane decode/read stages and the ALU.

## Interface
- NREQ, 4: number of requesters; power of two, 2..8.
- ALU_LAT, 2: register stages inside the ALU (fr_* capture to result valid).
- NOP_INS, 16'hF000: instruction driven to the ALU when no op is issued. Opcode F has no side effects and produces result 0.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  lane i has an op pending.
- req_ins  in  16*NREQ  instruction, lane i at [16i+15:16i].
- req_pc  in  16*NREQ  PC per lane.
- req_op1, req_op2  in  16*NREQ each  operands per lane.
- req_grant  out  NREQ  one-hot (or zero): lane i's op is accepted this cycle.
- stall  in  1  suppress new grants this cycle.
- flush  in  1  kill every op accepted but not yet responded.
- alu_ins, alu_pc, alu_op1, alu_op2  out  16 each  to ALU fr_ins/fr_pc/fr_operand_1/fr_operand_2.
- alu_result  in  16  ALU x2_result.
- rsp_valid  out  1  result valid this cycle.
- rsp_id  out  log2(NREQ)  originating lane.
- rsp_data  out  16  equals alu_result when rsp_valid, else 0.
- busy  out  1  any valid tag in flight.

## Operation
- Accept happens in a cycle where req_valid[i] and req_grant[i] are both high. A requester holds valid and payload stable until granted.
- Arbitration (combinational):
  - No grant when stall or flush is high.
  - Otherwise, grant the first i with req_valid[i], scanning from rr_ptr upward modulo NREQ.
- rr_ptr updates only on accept, to (granted index + 1) mod NREQ. Wrap from NREQ-1 goes to 0.
- Issue register:
  - On accept, latch the winner's ins/pc/op1/op2, set iss_valid, and set iss_id to the winner.
  - With no accept, load NOP_INS, pc 0, operands 0, and iss_valid 0.
  - alu_* are driven directly from the issue register.
- Tag pipe: ALU_LAT stages of {valid, id}. Stage 0 loads {iss_valid, iss_id}; each later stage loads its predecessor. The pipe advances every cycle; the ALU never stalls.
- rsp_valid = last-stage valid. rsp_id = last-stage id (0 when invalid). rsp_data = rsp_valid ? alu_result : 0.
- Flush:
  - Synchronously clears iss_valid and all tag valids at the next edge.
  - The ALU keeps computing the killed ops, but no response is produced.
  - An op responding in the same cycle flush is asserted still responds, because rsp is combinational off the current tag.
- busy = iss_valid OR any tag valid.
- Per-lane ordering is preserved (fixed latency, one issue per cycle).

## Timing
- Accept at edge E0. alu_* carry the op after E0. ALU captures at E1. The result is valid after E(ALU_LAT), so rsp_valid is high in the cycle following edge E0+ALU_LAT (3 edges after accept for the default).
- Throughput: one accept per cycle. Back-to-back accepts give back-to-back responses.
- Grant depends combinationally on req_valid, stall, flush, and rr_ptr. There is no combinational path from alu_result to req_grant.
- Reset (async, any time, including mid-flight):
  - rr_ptr = 0, iss_valid = 0, all tag valids = 0.
  - alu_ins = NOP_INS; alu_pc, alu_op1, alu_op2 = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, req_grant = 0 while rst is high.
  - In-flight ops are discarded with no response.
- Stall and flush high together: flush semantics, no grant.

## Test plan
- Single op: lane 2 requests add 3+4 → req_grant=4'b0100 same cycle; rsp_valid=1, rsp_id=2, rsp_data=7 three edges later; busy low afterwards.
- Contention: all four lanes valid continuously, lane i sub (10*i)-1 → grants in order 0,1,2,3,0; responses in order 0,1,2,3 with data 16'hFFFF, 9, 19, 29 on consecutive cycles.
- Pointer wrap and skip: rr_ptr=3 after granting lane 2, only lanes 0 and 3 valid → lane 3 granted, then lane 0; rr_ptr returns to 1.
- Stall: stall high for 2 cycles with lane 1 valid → no grant, alu_ins=16'hF000, no rsp. Grant occurs the cycle stall falls; response 3 edges later.
- Flush mid-flight: accept ops on lanes 0,1,2 on consecutive cycles, flush the cycle lane 0's response is presented → lane 0 responds, lanes 1 and 2 never respond, busy=0 next cycle.
- Async reset mid-flight: assert rst between edges with two ops in flight → all outputs go to reset values immediately; after release, no stale rsp_valid, and the first grant goes to lane 0 (rr_ptr=0).

Source files
------------

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of NREQ lane ops into a shared fixed-latency ALU; a tag pipe
// travels alongside each op so its result is routed back to the originating lane.
module alu_issue_scheduler #(
    parameter int          NREQ    = 4,
    parameter int          ALU_LAT = 2,
    parameter logic [15:0] NOP_INS = 16'hF000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [16*NREQ-1:0]      req_ins,
    input  logic [16*NREQ-1:0]      req_pc,
    input  logic [16*NREQ-1:0]      req_op1,
    input  logic [16*NREQ-1:0]      req_op2,
    output logic [NREQ-1:0]         req_grant,
    input  logic                    stall,
    input  logic                    flush,
    output logic [15:0]             alu_ins,
    output logic [15:0]             alu_pc,
    output logic [15:0]             alu_op1,
    output logic [15:0]             alu_op2,
    input  logic [15:0]             alu_result,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [15:0]             rsp_data,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]     r_rr_ptr;
    logic [NREQ-1:0]    w_grant;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_cand;
    logic               w_accept;

    logic               r_vld_p0;
    logic [IDW-1:0]     r_id_p0;
    logic [15:0]        r_ins_p0;
    logic [15:0]        r_pc_p0;
    logic [15:0]        r_op1_p0;
    logic [15:0]        r_op2_p0;

    logic [ALU_LAT-1:0] r_vld_pn;
    logic [IDW-1:0]     r_id_pn [ALU_LAT];

    // Arbitration: first valid lane at or after r_rr_ptr; index wraps by truncation.
    always_comb begin
        w_grant  = '0;
        w_win    = '0;
        w_cand   = '0;
        w_accept = 1'b0;
        if (!rst && !stall && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                w_cand = r_rr_ptr + k[IDW-1:0];
                if (!w_accept && req_valid[w_cand]) begin
                    w_accept = 1'b1;
                    w_win    = w_cand;
                end
            end
            if (w_accept) begin
                w_grant[w_win] = 1'b1;
            end
        end
    end

    // Stage p0: issue register feeding the ALU inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_vld_p0 <= 1'b0;
            r_id_p0  <= '0;
            r_ins_p0 <= NOP_INS;
            r_pc_p0  <= '0;
            r_op1_p0 <= '0;
            r_op2_p0 <= '0;
        end else if (w_accept) begin
            r_rr_ptr <= w_win + IDW'(1);
            r_vld_p0 <= 1'b1;
            r_id_p0  <= w_win;
            r_ins_p0 <= req_ins[{w_win, 4'b0000} +: 16];
            r_pc_p0  <= req_pc[{w_win, 4'b0000} +: 16];
            r_op1_p0 <= req_op1[{w_win, 4'b0000} +: 16];
            r_op2_p0 <= req_op2[{w_win, 4'b0000} +: 16];
        end else begin
            r_vld_p0 <= 1'b0;
            r_id_p0  <= '0;
            r_ins_p0 <= NOP_INS;
            r_pc_p0  <= '0;
            r_op1_p0 <= '0;
            r_op2_p0 <= '0;
        end
    end

    // Stages p1..pN: tag pipe mirroring the ALU latency; flush kills every live tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pn <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                r_id_pn[k] <= '0;
            end
        end else begin
            r_vld_pn[0] <= r_vld_p0 & ~flush;
            r_id_pn[0]  <= r_id_p0;
            for (int k = 1; k < ALU_LAT; k++) begin
                r_vld_pn[k] <= r_vld_pn[k-1] & ~flush;
                r_id_pn[k]  <= r_id_pn[k-1];
            end
        end
    end

    assign req_grant = w_grant;
    assign alu_ins   = r_ins_p0;
    assign alu_pc    = r_pc_p0;
    assign alu_op1   = r_op1_p0;
    assign alu_op2   = r_op2_p0;
    assign rsp_valid = r_vld_pn[ALU_LAT-1];
    assign rsp_id    = rsp_valid ? r_id_pn[ALU_LAT-1] : '0;
    assign rsp_data  = rsp_valid ? alu_result : 16'h0000;
    assign busy      = r_vld_p0 | (|r_vld_pn);

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler with a two-stage ALU model
// (opcode 0 add, 1 sub, anything else yields 0).
module tb_alu_issue_scheduler;
    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [63:0]     req_ins, req_pc, req_op1, req_op2;
    logic [NREQ-1:0] req_grant;
    logic            stall, flush;
    logic [15:0]     alu_ins, alu_pc, alu_op1, alu_op2, alu_result;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_data;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_issue_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ins(req_ins),
        .req_pc(req_pc), .req_op1(req_op1), .req_op2(req_op2),
        .req_grant(req_grant), .stall(stall), .flush(flush),
        .alu_ins(alu_ins), .alu_pc(alu_pc), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [15:0] alu_fn(input logic [15:0] ins, input logic [15:0] a,
                                           input logic [15:0] b);
        case (ins[15:12])
            4'h0:    return a + b;
            4'h1:    return a - b;
            default: return 16'h0000;
        endcase
    endfunction

    logic [15:0] m_s1 = '0;
    logic [15:0] m_s2 = '0;
    always @(posedge clk) begin
        m_s1 <= alu_fn(alu_ins, alu_op1, alu_op2);
        m_s2 <= m_s1;
    end
    assign alu_result = m_s2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] ins, input logic [15:0] a,
                            input logic [15:0] b);
        req_ins[16*i +: 16] = ins;
        req_op1[16*i +: 16] = a;
        req_op2[16*i +: 16] = b;
        req_pc[16*i +: 16]  = 16'h0100 + 16'(i);
    endtask

    task automatic drive(input logic [3:0] v, input logic s, input logic f);
        @(negedge clk);
        req_valid = v;
        stall     = s;
        flush     = f;
        #1;
    endtask

    task automatic look(input string tag, input logic [3:0] g, input logic rv,
                        input logic [1:0] rid, input logic [15:0] rd);
        check({tag, ".grant"}, 32'(req_grant), 32'(g));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, ".rsp_id"}, 32'(rsp_id), 32'(rid));
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'(rd));
    endtask

    logic [3:0]  c_g  [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0, 4'b0, 4'b0, 4'b0};
    logic        c_rv [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    logic [1:0]  c_id [9] = '{0, 0, 0, 0, 1, 2, 3, 0, 0};
    logic [15:0] c_d  [9] = '{0, 0, 0, 16'hFFFF, 9, 19, 29, 16'hFFFF, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t, required end before", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 4'b1111; stall = 1'b0; flush = 1'b0;
        req_ins = '0; req_pc = '0; req_op1 = '0; req_op2 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.grant", 32'(req_grant), 32'h0);
        check("rst.alu_ins", 32'(alu_ins), 32'hF000);
        check("rst.rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;

        // Single op: lane 2 add 3+4
        set_lane(2, 16'h0000, 16'd3, 16'd4);
        drive(4'b0100, 0, 0); look("t1.c0", 4'b0100, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t1.c1", 4'b0000, 0, 0, 0);
        check("t1.alu_ins", 32'(alu_ins), 32'h0000);
        check("t1.alu_pc", 32'(alu_pc), 32'h0102);
        check("t1.alu_op1", 32'(alu_op1), 32'd3);
        check("t1.alu_op2", 32'(alu_op2), 32'd4);
        check("t1.busy", 32'(busy), 32'h1);
        drive(4'b0000, 0, 0); look("t1.c2", 4'b0000, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t1.c3", 4'b0000, 1, 2, 16'd7);
        drive(4'b0000, 0, 0); look("t1.c4", 4'b0000, 0, 0, 0);
        check("t1.busy_end", 32'(busy), 32'h0);
        check("t1.alu_nop", 32'(alu_ins), 32'hF000);

        // Pointer wrap and skip (rr_ptr=3)
        set_lane(3, 16'h0000, 16'd5, 16'd6);
        set_lane(0, 16'h1000, 16'd8, 16'd3);
        set_lane(1, 16'h0000, 16'd1, 16'd1);
        drive(4'b1001, 0, 0); look("t3.c0", 4'b1000, 0, 0, 0);
        drive(4'b0001, 0, 0); look("t3.c1", 4'b0001, 0, 0, 0);
        drive(4'b0011, 0, 0); look("t3.c2", 4'b0010, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t3.c3", 4'b0000, 1, 3, 16'd11);
        drive(4'b0000, 0, 0); look("t3.c4", 4'b0000, 1, 0, 16'd5);
        drive(4'b0000, 0, 0); look("t3.c5", 4'b0000, 1, 1, 16'd2);
        drive(4'b0000, 0, 0); look("t3.c6", 4'b0000, 0, 0, 0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Contention: all lanes valid, lane i computes 10*i - 1
        for (int i = 0; i < NREQ; i++) set_lane(i, 16'h1000, 16'(10 * i), 16'd1);
        for (int c = 0; c < 9; c++) begin
            drive((c < 5) ? 4'b1111 : 4'b0000, 0, 0);
            look($sformatf("t2.c%0d", c), c_g[c], c_rv[c], c_id[c], c_d[c]);
        end

        // Stall for two cycles with lane 1 valid
        set_lane(1, 16'h0000, 16'd20, 16'd22);
        drive(4'b0010, 1, 0); look("t4.c0", 4'b0000, 0, 0, 0);
        check("t4.alu_ins0", 32'(alu_ins), 32'hF000);
        drive(4'b0010, 1, 0); look("t4.c1", 4'b0000, 0, 0, 0);
        check("t4.alu_ins1", 32'(alu_ins), 32'hF000);
        check("t4.busy", 32'(busy), 32'h0);
        drive(4'b0010, 0, 0); look("t4.c2", 4'b0010, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t4.c3", 4'b0000, 0, 0, 0);
        check("t4.alu_op1", 32'(alu_op1), 32'd20);
        drive(4'b0000, 0, 0); look("t4.c4", 4'b0000, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t4.c5", 4'b0000, 1, 1, 16'd42);
        drive(4'b0000, 0, 0); look("t4.c6", 4'b0000, 0, 0, 0);

        // Flush while lane 0's response is presented (rr_ptr=2)
        set_lane(0, 16'h0000, 16'd100, 16'd1);
        set_lane(1, 16'h0000, 16'd7, 16'd7);
        set_lane(2, 16'h1000, 16'd9, 16'd2);
        drive(4'b0001, 0, 0); look("t5.c0", 4'b0001, 0, 0, 0);
        drive(4'b0010, 0, 0); look("t5.c1", 4'b0010, 0, 0, 0);
        drive(4'b0100, 0, 0); look("t5.c2", 4'b0100, 0, 0, 0);
        drive(4'b1000, 0, 1); look("t5.c3", 4'b0000, 1, 0, 16'd101);
        drive(4'b0000, 0, 0); look("t5.c4", 4'b0000, 0, 0, 0);
        check("t5.busy", 32'(busy), 32'h0);
        drive(4'b0000, 0, 0); look("t5.c5", 4'b0000, 0, 0, 0);
        drive(4'b0000, 0, 0); look("t5.c6", 4'b0000, 0, 0, 0);

        // Async reset with two ops in flight (rr_ptr=3)
        drive(4'b0001, 0, 0); look("t6.c0", 4'b0001, 0, 0, 0);
        drive(4'b0010, 0, 0); look("t6.c1", 4'b0010, 0, 0, 0);
        drive(4'b0000, 0, 0);
        check("t6.busy_pre", 32'(busy), 32'h1);
        #2;
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        check("t6.rst_grant", 32'(req_grant), 32'h0);
        check("t6.rst_alu_ins", 32'(alu_ins), 32'hF000);
        check("t6.rst_alu_pc", 32'(alu_pc), 32'h0);
        check("t6.rst_alu_op1", 32'(alu_op1), 32'h0);
        check("t6.rst_alu_op2", 32'(alu_op2), 32'h0);
        check("t6.rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("t6.rst_rsp_id", 32'(rsp_id), 32'h0);
        check("t6.rst_rsp_data", 32'(rsp_data), 32'h0);
        check("t6.rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0; req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0000, 0, 0);
            look($sformatf("t6.post%0d", c), 4'b0000, 0, 0, 0);
        end
        drive(4'b1111, 0, 0); look("t6.first", 4'b0001, 0, 0, 0);
        drive(4'b0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
